mouse_packet_rx: RTL and testbench

MOUSE_PACKET_RX -- requirements
Module: mouse_packet_rx

---
 rtl/mouse_packet_rx_if.sv | 25 ++
 rtl/mouse_packet_rx.sv | 128 ++++++++++++
 tb/tb_mouse_packet_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mouse_packet_rx_if.sv
// Bus between the PS/2 byte transceiver side and the mouse packet receiver.
// master drives received bytes and transmit completion; slave is mouse_packet_rx.
`timescale 1ns/1ps
interface mouse_packet_rx_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] tx_data;
  logic       wr_ps2;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic       init_done;

  modport master (
    output rx_data, rx_done_tick, tx_done_tick,
    input  tx_data, wr_ps2, xm, ym, btnm, m_done_tick, init_done
  );

  modport slave (
    input  rx_data, rx_done_tick, tx_done_tick,
    output tx_data, wr_ps2, xm, ym, btnm, m_done_tick, init_done
  );
endinterface

// File: rtl/mouse_packet_rx.sv
// PS/2 mouse front end: sends the stream-enable command, waits for the ACK,
// then assembles 3-byte movement packets with an inter-byte timeout.
`timescale 1ns/1ps
module mouse_packet_rx #(
  parameter int TMO_CYCLES = 2500000
) (
  input logic              clk,
  input logic              reset,
  mouse_packet_rx_if.slave bus
);
  localparam int CW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES);

  typedef enum logic [2:0] {
    INIT_WR, INIT_TX, INIT_ACK, PKT1, PKT2, PKT3, DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] tmo_cnt_q;
  logic [2:0]    btn_pend_q;
  logic          x_sign_q;
  logic          y_sign_q;
  logic          x_ovf_q;
  logic          y_ovf_q;
  logic [7:0]    x_low_q;
  logic          wr_ps2_q;
  logic          init_done_q;
  logic          m_done_q;
  logic [8:0]    xm_q;
  logic [8:0]    ym_q;
  logic [2:0]    btnm_q;
  logic          tmo_hit;
  logic          in_body;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  assign in_body = (state_q == PKT2) || (state_q == PKT3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT_WR;
      tmo_cnt_q   <= '0;
      btn_pend_q  <= '0;
      x_sign_q    <= 1'b0;
      y_sign_q    <= 1'b0;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
      x_low_q     <= '0;
      wr_ps2_q    <= 1'b0;
      init_done_q <= 1'b0;
      m_done_q    <= 1'b0;
      xm_q        <= '0;
      ym_q        <= '0;
      btnm_q      <= '0;
    end else begin
      wr_ps2_q <= 1'b0;
      m_done_q <= 1'b0;
      case (state_q)
        INIT_WR: begin
          wr_ps2_q <= 1'b1;
          state_q  <= INIT_TX;
        end
        INIT_TX: begin
          if (bus.tx_done_tick) state_q <= INIT_ACK;
        end
        INIT_ACK: begin
          if (bus.rx_done_tick) begin
            if (bus.rx_data == 8'hFA) begin
              init_done_q <= 1'b1;
              state_q     <= PKT1;
            end else begin
              state_q <= INIT_WR;
            end
          end
        end
        PKT1: begin
          // Bit 3 is always set in a genuine first byte; anything else is a resync.
          if (bus.rx_done_tick && bus.rx_data[3]) begin
            btn_pend_q <= bus.rx_data[2:0];
            x_sign_q   <= bus.rx_data[4];
            y_sign_q   <= bus.rx_data[5];
            x_ovf_q    <= bus.rx_data[6];
            y_ovf_q    <= bus.rx_data[7];
            state_q    <= PKT2;
          end
        end
        PKT2: begin
          if (bus.rx_done_tick) begin
            x_low_q <= bus.rx_data;
            state_q <= PKT3;
          end else if (tmo_hit) begin
            state_q <= PKT1;
          end
        end
        PKT3: begin
          // Outputs load on the third byte so they appear together with the tick.
          if (bus.rx_done_tick) begin
            btnm_q   <= btn_pend_q;
            xm_q     <= x_ovf_q ? 9'd0 : {x_sign_q, x_low_q};
            ym_q     <= y_ovf_q ? 9'd0 : {y_sign_q, bus.rx_data};
            m_done_q <= 1'b1;
            state_q  <= DONE;
          end else if (tmo_hit) begin
            state_q <= PKT1;
          end
        end
        DONE: begin
          state_q <= PKT1;
        end
        default: begin
          state_q <= INIT_WR;
        end
      endcase

      if (in_body && !bus.rx_done_tick && !tmo_hit)
        tmo_cnt_q <= tmo_cnt_q + CW'(1);
      else
        tmo_cnt_q <= '0;
    end
  end

  assign bus.tx_data     = 8'hF4;
  assign bus.wr_ps2      = wr_ps2_q;
  assign bus.init_done   = init_done_q;
  assign bus.m_done_tick = m_done_q;
  assign bus.xm          = xm_q;
  assign bus.ym          = ym_q;
  assign bus.btnm        = btnm_q;
endmodule

// File: tb/tb_mouse_packet_rx.sv
// Bench for mouse_packet_rx: init handshake, packet vectors, resync, timeout, reset abort.
`timescale 1ns/1ps
module tb_mouse_packet_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   tick_cnt = 0;
  int   wr_cnt = 0;

  mouse_packet_rx_if bus ();

  mouse_packet_rx #(.TMO_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.m_done_tick) tick_cnt++;
    if (bus.wr_ps2) wr_cnt++;
  end

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } vec_t;

  typedef struct {
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } exp_t;

  localparam int NV = 7;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
  endtask

  task automatic pulse_tx();
    bus.tx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1);
    idle(1);
    send_byte(b2);
    idle(2);
    send_byte(b3);
  endtask

  // Called right after the third byte: the tick must already be up.
  task automatic expect_pkt(input string name);
    exp_t e;
    int   waited;
    waited = 0;
    while (!bus.m_done_tick && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk({name, "_lat"}, waited, 0);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_xm"}, {23'd0, bus.xm}, {23'd0, e.xm});
      chk({name, "_ym"}, {23'd0, bus.ym}, {23'd0, e.ym});
      chk({name, "_btn"}, {29'd0, bus.btnm}, {29'd0, e.btn});
    end
    idle(1);
    chk({name, "_pulse"}, {31'd0, bus.m_done_tick}, 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {8'd0, bus.wr_ps2, bus.init_done, bus.xm, bus.ym, bus.btnm, bus.m_done_tick}, 0);
  endtask

  initial begin
    int t0;
    int w0;
    vecs[0] = '{8'h29, 8'h05, 8'hFB, 9'h005, 9'h1FB, 3'b001};
    vecs[1] = '{8'h0A, 8'h10, 8'h20, 9'h010, 9'h020, 3'b010};
    vecs[2] = '{8'h48, 8'h7F, 8'h02, 9'h000, 9'h002, 3'b000};
    vecs[3] = '{8'h3C, 8'h80, 8'h7F, 9'h180, 9'h17F, 3'b100};
    vecs[4] = '{8'h8F, 8'h12, 8'h34, 9'h012, 9'h000, 3'b111};
    vecs[5] = '{8'hC9, 8'h55, 8'h66, 9'h000, 9'h000, 3'b001};
    vecs[6] = '{8'h18, 8'hFF, 8'h01, 9'h1FF, 9'h001, 3'b000};

    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    idle(3);
    chk_reset_outs("reset_outs");
    reset = 1'b0;

    // Command write, stray byte while transmitting, NAK retry, then ACK.
    idle(3);
    chk("wr_pulse1", wr_cnt, 1);
    chk("tx_data", {24'd0, bus.tx_data}, 32'h0000_00F4);
    send_byte(8'hFA);
    chk("init_ignored_in_tx", {31'd0, bus.init_done}, 0);
    pulse_tx();
    send_byte(8'hAA);
    idle(3);
    chk("wr_retry", wr_cnt, 2);
    chk("init_after_nak", {31'd0, bus.init_done}, 0);
    pulse_tx();
    send_byte(8'hFA);
    chk("init_done", {31'd0, bus.init_done}, 1);
    chk("no_tick_init", tick_cnt, 0);
    pulse_tx();
    idle(2);
    chk("wr_no_extra", wr_cnt, 2);

    for (int i = 0; i < NV; i++) begin
      t0 = tick_cnt;
      sb.push_back('{vecs[i].xm, vecs[i].ym, vecs[i].btn});
      send_pkt(vecs[i].b1, vecs[i].b2, vecs[i].b3);
      expect_pkt($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ticks", i), tick_cnt - t0, 1);
      idle(2);
    end

    // Byte without bit 3 is dropped before a valid packet.
    t0 = tick_cnt;
    send_byte(8'h01);
    idle(1);
    sb.push_back('{9'h010, 9'h020, 3'b010});
    send_pkt(8'h0A, 8'h10, 8'h20);
    expect_pkt("resync");
    chk("resync_ticks", tick_cnt - t0, 1);

    // Timeout in PKT3: partial packet discarded, outputs held.
    t0 = tick_cnt;
    send_byte(8'h08);
    idle(1);
    send_byte(8'h33);
    idle(101);
    chk("tmo3_notick", tick_cnt - t0, 0);
    chk("tmo3_hold_xm", {23'd0, bus.xm}, 32'h010);
    chk("tmo3_hold_ym", {23'd0, bus.ym}, 32'h020);
    sb.push_back('{9'h1FF, 9'h001, 3'b000});
    send_pkt(8'h18, 8'hFF, 8'h01);
    expect_pkt("tmo3_next");
    chk("tmo3_ticks", tick_cnt - t0, 1);

    // Timeout in PKT2.
    t0 = tick_cnt;
    send_byte(8'h28);
    idle(101);
    sb.push_back('{9'h001, 9'h002, 3'b001});
    send_pkt(8'h09, 8'h01, 8'h02);
    expect_pkt("tmo2_next");
    chk("tmo2_ticks", tick_cnt - t0, 1);

    // Overflow packet, then reset in the middle of the next packet.
    sb.push_back('{9'h000, 9'h002, 3'b000});
    send_pkt(8'h48, 8'h7F, 8'h02);
    expect_pkt("ovf");
    idle(1);
    send_byte(8'h09);
    t0 = tick_cnt;
    reset = 1'b1;
    #1;
    chk_reset_outs("midpkt_reset_outs");
    idle(2);
    w0 = wr_cnt;
    reset = 1'b0;
    idle(3);
    chk("midpkt_wr_again", wr_cnt - w0, 1);
    chk("midpkt_no_tick", tick_cnt - t0, 0);
    pulse_tx();
    send_byte(8'hFA);
    chk("reinit_done", {31'd0, bus.init_done}, 1);
    sb.push_back('{9'h005, 9'h1FB, 3'b001});
    send_pkt(8'h29, 8'h05, 8'hFB);
    expect_pkt("after_reset");

    idle(3);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
